ins_page_loader: RTL
====================

Name: ins_page_loader

Overview:
Refill controller for the instruction cache. Sequences page loads of ISA_DEPTH instructions from DDR into the cache RAM, and decides when a new page is needed from the PC fetch address. Drives the ready, state and load-count signals consumed by program_counter. Sits between program_counter, the instruction cache RAM and the DDR read port.

Parameters:
ADDR_WIDTH_MEM, 16, width of PC/instruction addresses
ISA_DEPTH, 64, instructions per cache page (power of two)
TOTAL_ISA_DEPTH, 128, total program length in instructions
DDR_ADDR_WIDTH, 28, DDR byte-address width
DATA_WIDTH, 64, instruction / DDR beat width
ISA_DDR_BASE, 0, DDR byte address of instruction 0

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
addr_ins  in  ADDR_WIDTH_MEM  current PC fetch address (instruction index)
ins_cache_rdy  out  1  cache holds a valid page
st_cur_ins_cache  out  4  current state encoding
load_times  out  10  resident page index + 1
ins_out_of_range  out  1  addr_ins >= TOTAL_ISA_DEPTH
ddr_rd_req  out  1  DDR burst read request
ddr_rd_addr  out  DDR_ADDR_WIDTH  burst start byte address
ddr_rd_gnt  in  1  request accepted this cycle
ddr_rd_data_valid  in  1  read beat valid
ddr_rd_data  in  DATA_WIDTH  read beat data
cache_wr_en  out  1  cache RAM write strobe
cache_wr_addr  out  ADDR_WIDTH_MEM  cache RAM word index (0..ISA_DEPTH-1)
cache_wr_data  out  DATA_WIDTH  cache RAM write data

Behaviour:
- Single clock clk. rst is asynchronous and active-high. All outputs are registered.
- Reset values: all outputs 0 except st_cur_ins_cache = INIT. Internal resident_page = 0, beat_cnt = 0, target_page = 0.
- State encodings: INIT=4'd1, LOAD_REQ=4'd2, SENT_INS=4'd3, LOAD_DATA=4'd4. Any other value goes to INIT.
- INIT: one cycle, then LOAD_REQ with target_page = 0 (boot load).
- LOAD_REQ:
  - ddr_rd_req = 1 and ddr_rd_addr = ISA_DDR_BASE + target_page*ISA_DEPTH*8; the address is truncated to DDR_ADDR_WIDTH.
  - Hold both until ddr_rd_gnt is sampled 1. The next state is then LOAD_DATA, and ddr_rd_req is 0 from the following cycle.
  - ins_cache_rdy = 0.
- LOAD_DATA:
  - Each cycle with ddr_rd_data_valid = 1: on the next cycle cache_wr_en = 1, cache_wr_addr = beat_cnt, cache_wr_data = ddr_rd_data; beat_cnt then increments.
  - Gaps in valid are allowed. Beats arriving in any other state are ignored.
  - On beat ISA_DEPTH-1: beat_cnt clears, resident_page = target_page, load_times = target_page + 1, state goes to SENT_INS.
  - ins_cache_rdy = 1 from the first cycle in SENT_INS, one cycle after the last write strobe.
- SENT_INS:
  - ins_cache_rdy = 1. page = addr_ins / ISA_DEPTH.
  - If addr_ins < TOTAL_ISA_DEPTH and page != resident_page: target_page = page, go to LOAD_REQ, and ins_cache_rdy = 0 on the next cycle.
  - The PC stalls at addr_ins == ISA_DEPTH*load_times, which is page resident+1, so this rule also triggers the sequential advance.
- ins_out_of_range: registered compare, valid in every state. No load is started for an out-of-range address; the controller stays in SENT_INS with rdy = 1.
- Changes to addr_ins during LOAD_REQ or LOAD_DATA are ignored. They are re-evaluated on entry to SENT_INS, so a second load may follow immediately.
- load_times saturates at 1023 (page index arithmetic is 10 bits).
- Reset mid-load: immediate return to INIT with req, wr_en and rdy dropped. Late DDR beats are ignored and the boot load restarts.
- No reload when page == resident_page, even after a jump.

Test Plan:
- Reset release, gnt 2 cycles after req, 64 back-to-back beats -> ddr_rd_addr = 0x0, 64 writes at addr 0..63, rdy = 1, st = 3, load_times = 1.
- In SENT_INS with resident page 0, addr_ins = 64 -> req with ddr_rd_addr = 0x200; rdy is 0 during the load; after the load load_times = 2 and the data is written at cache addr 0..63.
- Resident page 1, addr_ins = 10 (jump back) -> reload page 0 at ddr_rd_addr = 0x0, load_times = 1. Same-page jump to addr_ins = 70 -> no req.
- addr_ins = 128 -> ins_out_of_range = 1, no ddr_rd_req, rdy stays 1.
- data_valid toggling 1/0 every cycle -> exactly 64 writes with contiguous cache_wr_addr, and rdy rises one cycle after the last write.
- rst asserted after the 30th beat, with beats continuing through the reset -> outputs cleared, st = 1, then a fresh page-0 request; stale beats are never written.

Source files
------------

// File: rtl/ins_page_loader.sv
`default_nettype none
// ins_page_loader: instruction-cache refill controller. It fetches ISA_DEPTH-instruction
// pages from DDR into the cache RAM whenever the PC leaves the resident page.
module ins_page_loader #(
  parameter int ADDR_WIDTH_MEM  = 16,
  parameter int ISA_DEPTH       = 64,
  parameter int TOTAL_ISA_DEPTH = 128,
  parameter int DDR_ADDR_WIDTH  = 28,
  parameter int DATA_WIDTH      = 64,
  parameter int ISA_DDR_BASE    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH_MEM-1:0] addr_ins,
  output logic                      ins_cache_rdy,
  output logic [3:0]                st_cur_ins_cache,
  output logic [9:0]                load_times,
  output logic                      ins_out_of_range,
  output logic                      ddr_rd_req,
  output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr,
  input  logic                      ddr_rd_gnt,
  input  logic                      ddr_rd_data_valid,
  input  logic [DATA_WIDTH-1:0]     ddr_rd_data,
  output logic                      cache_wr_en,
  output logic [ADDR_WIDTH_MEM-1:0] cache_wr_addr,
  output logic [DATA_WIDTH-1:0]     cache_wr_data
);

  localparam logic [3:0] INIT      = 4'd1;
  localparam logic [3:0] LOAD_REQ  = 4'd2;
  localparam logic [3:0] SENT_INS  = 4'd3;
  localparam logic [3:0] LOAD_DATA = 4'd4;

  localparam int BEAT_W     = $clog2(ISA_DEPTH);
  localparam int PAGE_SHIFT = $clog2(ISA_DEPTH * 8);
  localparam logic [ADDR_WIDTH_MEM:0]   TOTAL     = (ADDR_WIDTH_MEM + 1)'(TOTAL_ISA_DEPTH);
  localparam logic [DDR_ADDR_WIDTH-1:0] DDR_BASE  = DDR_ADDR_WIDTH'(ISA_DDR_BASE);
  localparam logic [BEAT_W-1:0]         LAST_BEAT = BEAT_W'(ISA_DEPTH - 1);

  logic [3:0]                state, state_nxt;
  logic [9:0]                resident_page, target_page, target_nxt, page;
  logic [BEAT_W-1:0]         beat_cnt;
  logic                      last_wr;
  logic                      in_range, need_load, beat_acc, last_beat;
  logic                      req_nxt, rdy_nxt;
  logic [DDR_ADDR_WIDTH-1:0] ddr_addr_nxt;

  assign page      = 10'(addr_ins >> BEAT_W);
  assign in_range  = {1'b0, addr_ins} < TOTAL;
  assign need_load = in_range && (page != resident_page);
  // Beats are taken only while the final write of the page is not yet out.
  assign beat_acc  = (state == LOAD_DATA) && ddr_rd_data_valid && !last_wr;
  assign last_beat = beat_acc && (beat_cnt == LAST_BEAT);
  assign st_cur_ins_cache = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    target_nxt = target_page;
    case (state)
      INIT: begin
        state_nxt  = LOAD_REQ;
        target_nxt = 10'd0;
      end
      LOAD_REQ:  if (ddr_rd_gnt) state_nxt = LOAD_DATA;
      LOAD_DATA: if (last_wr) state_nxt = SENT_INS;
      SENT_INS: begin
        if (need_load) begin
          state_nxt  = LOAD_REQ;
          target_nxt = page;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    req_nxt      = (state_nxt == LOAD_REQ);
    rdy_nxt      = (state_nxt == SENT_INS);
    ddr_addr_nxt = DDR_BASE + (DDR_ADDR_WIDTH'(target_nxt) << PAGE_SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ddr_rd_req    <= 1'b0;
      ins_cache_rdy <= 1'b0;
      ddr_rd_addr   <= '0;
    end else begin
      ddr_rd_req    <= req_nxt;
      ins_cache_rdy <= rdy_nxt;
      ddr_rd_addr   <= ddr_addr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_page      <= 10'd0;
      resident_page    <= 10'd0;
      beat_cnt         <= '0;
      last_wr          <= 1'b0;
      load_times       <= 10'd0;
      ins_out_of_range <= 1'b0;
      cache_wr_en      <= 1'b0;
      cache_wr_addr    <= '0;
      cache_wr_data    <= '0;
    end else begin
      target_page      <= target_nxt;
      ins_out_of_range <= !in_range;
      cache_wr_en      <= beat_acc;
      last_wr          <= last_beat;
      if (beat_acc) begin
        cache_wr_addr <= ADDR_WIDTH_MEM'(beat_cnt);
        cache_wr_data <= ddr_rd_data;
        beat_cnt      <= last_beat ? '0 : beat_cnt + 1'b1;
      end
      if (last_beat) begin
        resident_page <= target_page;
        load_times    <= (target_page == 10'd1023) ? 10'd1023 : target_page + 10'd1;
      end
    end
  end

endmodule
`default_nettype wire
